// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port memory between instruction fetch (IF) and load/store (LS).
// LS has fixed priority; a starvation counter forces an IF grant after STARVE_MAX losses.
`timescale 1ns/1ps
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                ls_req,
    input  logic                ls_we,
    input  logic [ADDR_W-1:0]   ls_addr,
    input  logic [DATA_W-1:0]   ls_wdata,
    input  logic [DATA_W/8-1:0] ls_be,
    output logic                ls_gnt,
    output logic                ls_rvalid,
    output logic [DATA_W-1:0]   ls_rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);
    localparam int BE_W = DATA_W / 8;
    localparam logic [3:0] STARVE_MAX_C = 4'(STARVE_MAX);
    localparam logic [3:0] LAT_LOAD     = 4'(MEM_LAT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t              state_reg, state_next;
    logic [3:0]          starve_cnt_reg, starve_cnt_next;
    logic [3:0]          lat_cnt_reg, lat_cnt_next;
    logic                sel_ls_reg, sel_ls_next;
    logic                if_gnt_reg, if_gnt_next;
    logic                if_rvalid_reg, if_rvalid_next;
    logic [DATA_W-1:0]   if_rdata_reg, if_rdata_next;
    logic                ls_gnt_reg, ls_gnt_next;
    logic                ls_rvalid_reg, ls_rvalid_next;
    logic [DATA_W-1:0]   ls_rdata_reg, ls_rdata_next;
    logic                mem_en_reg, mem_en_next;
    logic                mem_we_reg, mem_we_next;
    logic [ADDR_W-1:0]   mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0]   mem_wdata_reg, mem_wdata_next;
    logic [BE_W-1:0]     mem_be_reg, mem_be_next;
    logic                busy_reg, busy_next;
    logic                pick_if;

    always_comb begin
        state_next      = state_reg;
        starve_cnt_next = starve_cnt_reg;
        lat_cnt_next    = lat_cnt_reg;
        sel_ls_next     = sel_ls_reg;
        if_gnt_next     = 1'b0;
        if_rvalid_next  = 1'b0;
        if_rdata_next   = if_rdata_reg;
        ls_gnt_next     = 1'b0;
        ls_rvalid_next  = 1'b0;
        ls_rdata_next   = ls_rdata_reg;
        mem_en_next     = 1'b0;
        mem_we_next     = mem_we_reg;
        mem_addr_next   = mem_addr_reg;
        mem_wdata_next  = mem_wdata_reg;
        mem_be_next     = mem_be_reg;
        pick_if         = 1'b0;

        case (state_reg)
            IDLE: begin
                if (if_req || ls_req) begin
                    pick_if     = (starve_cnt_reg == STARVE_MAX_C && if_req) || !ls_req;
                    mem_en_next = 1'b1;
                    state_next  = ISSUE;
                    if (pick_if) begin
                        sel_ls_next     = 1'b0;
                        if_gnt_next     = 1'b1;
                        mem_we_next     = 1'b0;
                        mem_addr_next   = if_addr;
                        mem_wdata_next  = '0;
                        mem_be_next     = '1;
                        starve_cnt_next = 4'd0;
                    end else begin
                        sel_ls_next    = 1'b1;
                        ls_gnt_next    = 1'b1;
                        mem_we_next    = ls_we;
                        mem_addr_next  = ls_addr;
                        mem_wdata_next = ls_wdata;
                        mem_be_next    = ls_be;
                        // Count only losses while IF is actually waiting.
                        if (!if_req)
                            starve_cnt_next = 4'd0;
                        else if (starve_cnt_reg != STARVE_MAX_C)
                            starve_cnt_next = starve_cnt_reg + 4'd1;
                    end
                end
            end
            ISSUE: begin
                lat_cnt_next = LAT_LOAD;
                state_next   = (MEM_LAT == 1) ? RESP : WAIT;
            end
            WAIT: begin
                lat_cnt_next = lat_cnt_reg - 4'd1;
                if (lat_cnt_reg <= 4'd1)
                    state_next = RESP;
            end
            RESP: begin
                state_next = IDLE;
                if (sel_ls_reg) begin
                    ls_rvalid_next = 1'b1;
                    ls_rdata_next  = mem_we_reg ? '0 : mem_rdata;
                end else begin
                    if_rvalid_next = 1'b1;
                    if_rdata_next  = mem_rdata;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= 4'd0;
            lat_cnt_reg    <= 4'd0;
            sel_ls_reg     <= 1'b0;
            if_gnt_reg     <= 1'b0;
            if_rvalid_reg  <= 1'b0;
            if_rdata_reg   <= '0;
            ls_gnt_reg     <= 1'b0;
            ls_rvalid_reg  <= 1'b0;
            ls_rdata_reg   <= '0;
            mem_en_reg     <= 1'b0;
            mem_we_reg     <= 1'b0;
            mem_addr_reg   <= '0;
            mem_wdata_reg  <= '0;
            mem_be_reg     <= '0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            starve_cnt_reg <= starve_cnt_next;
            lat_cnt_reg    <= lat_cnt_next;
            sel_ls_reg     <= sel_ls_next;
            if_gnt_reg     <= if_gnt_next;
            if_rvalid_reg  <= if_rvalid_next;
            if_rdata_reg   <= if_rdata_next;
            ls_gnt_reg     <= ls_gnt_next;
            ls_rvalid_reg  <= ls_rvalid_next;
            ls_rdata_reg   <= ls_rdata_next;
            mem_en_reg     <= mem_en_next;
            mem_we_reg     <= mem_we_next;
            mem_addr_reg   <= mem_addr_next;
            mem_wdata_reg  <= mem_wdata_next;
            mem_be_reg     <= mem_be_next;
            busy_reg       <= busy_next;
        end
    end

    assign if_gnt    = if_gnt_reg;
    assign if_rvalid = if_rvalid_reg;
    assign if_rdata  = if_rdata_reg;
    assign ls_gnt    = ls_gnt_reg;
    assign ls_rvalid = ls_rvalid_reg;
    assign ls_rdata  = ls_rdata_reg;
    assign mem_en    = mem_en_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign mem_be    = mem_be_reg;
    assign busy      = busy_reg;
endmodule

// File: tb/tb_mem_port_arbiter.sv
`timescale 1ns/1ps

module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;

    logic        if_req, ls_req, ls_we;
    logic [31:0] if_addr, ls_addr, ls_wdata;
    logic [3:0]  ls_be;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata, ls_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic [31:0] pipe2 [0:1];

    logic        if_req_sw;
    logic        l1_if_gnt, l1_if_rvalid, l1_ls_gnt, l1_ls_rvalid, l1_en, l1_we, l1_busy;
    logic [31:0] l1_if_rdata, l1_ls_rdata, l1_addr, l1_wdata, l1_rdata;
    logic [3:0]  l1_be;
    logic [31:0] pipe1 [0:0];
    logic        l15_if_gnt, l15_if_rvalid, l15_ls_gnt, l15_ls_rvalid, l15_en, l15_we, l15_busy;
    logic [31:0] l15_if_rdata, l15_ls_rdata, l15_addr, l15_wdata, l15_rdata;
    logic [3:0]  l15_be;
    logic [31:0] pipe15 [0:14];

    always #5 clk = ~clk;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEADBEEF;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) begin
        pipe2[0] <= mem_en ? rd(mem_addr) : 32'hBAD0BAD0;
        pipe2[1] <= pipe2[0];
        pipe1[0] <= l1_en ? rd(l1_addr) : 32'hBAD1BAD1;
        pipe15[0] <= l15_en ? rd(l15_addr) : 32'hBAD2BAD2;
        for (int i = 1; i < 15; i++) pipe15[i] <= pipe15[i-1];
    end
    assign mem_rdata = pipe2[1];
    assign l1_rdata  = pipe1[0];
    assign l15_rdata = pipe15[14];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(4)) u_dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_be(ls_be),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(4)) u_lat1 (
        .clk(clk), .reset(reset),
        .if_req(if_req_sw), .if_addr(32'h40), .if_gnt(l1_if_gnt), .if_rvalid(l1_if_rvalid), .if_rdata(l1_if_rdata),
        .ls_req(1'b0), .ls_we(1'b0), .ls_addr(32'h0), .ls_wdata(32'h0), .ls_be(4'h0),
        .ls_gnt(l1_ls_gnt), .ls_rvalid(l1_ls_rvalid), .ls_rdata(l1_ls_rdata),
        .mem_en(l1_en), .mem_we(l1_we), .mem_addr(l1_addr), .mem_wdata(l1_wdata), .mem_be(l1_be),
        .mem_rdata(l1_rdata), .busy(l1_busy)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(15), .STARVE_MAX(4)) u_lat15 (
        .clk(clk), .reset(reset),
        .if_req(if_req_sw), .if_addr(32'h40), .if_gnt(l15_if_gnt), .if_rvalid(l15_if_rvalid), .if_rdata(l15_if_rdata),
        .ls_req(1'b0), .ls_we(1'b0), .ls_addr(32'h0), .ls_wdata(32'h0), .ls_be(4'h0),
        .ls_gnt(l15_ls_gnt), .ls_rvalid(l15_ls_rvalid), .ls_rdata(l15_ls_rdata),
        .mem_en(l15_en), .mem_we(l15_we), .mem_addr(l15_addr), .mem_wdata(l15_wdata), .mem_be(l15_be),
        .mem_rdata(l15_rdata), .busy(l15_busy)
    );

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    initial begin
        int  lg1, le1, nr1, lg15, le15, nr15;
        logic seen;
        reset = 1'b0; if_req = 1'b0; if_addr = '0; if_req_sw = 1'b0;
        ls_req = 1'b0; ls_we = 1'b0; ls_addr = '0; ls_wdata = '0; ls_be = '0;

        steps(3);
        check("rst_if_gnt", if_gnt, 1'b0);
        check("rst_ls_gnt", ls_gnt, 1'b0);
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);
        reset = 1'b1;
        steps(1);

        if_req = 1'b1; if_addr = 32'h100;
        steps(1);
        check("t1_if_gnt", if_gnt, 1'b1);
        check("t1_ls_gnt", ls_gnt, 1'b0);
        check("t1_mem_en", mem_en, 1'b1);
        check("t1_mem_addr", mem_addr, 32'h100);
        check("t1_busy", busy, 1'b1);
        if_req = 1'b0;
        steps(1);
        check("t1_mem_en_low", mem_en, 1'b0);
        check("t1_mem_addr_hold", mem_addr, 32'h100);
        steps(1);
        check("t1_no_early_rvalid", if_rvalid, 1'b0);
        steps(1);
        check("t1_if_rvalid", if_rvalid, 1'b1);
        check("t1_if_rdata", if_rdata, 32'hDEADBEEF);
        check("t1_busy_idle", busy, 1'b0);

        if_req = 1'b1; if_addr = 32'h104;
        steps(1);
        check("t6_if_gnt", if_gnt, 1'b1);
        if_req = 1'b0;
        steps(1);
        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h208; ls_wdata = 32'h0; ls_be = 4'hF;
        check("t6_no_gnt_wait", ls_gnt, 1'b0);
        steps(1);
        check("t6_no_gnt_resp", ls_gnt, 1'b0);
        steps(1);
        check("t6_if_rvalid", if_rvalid, 1'b1);
        check("t6_if_rdata", if_rdata, 32'h0104FEFB);
        check("t6_no_gnt_idle", ls_gnt, 1'b0);
        steps(1);
        check("t6_ls_gnt", ls_gnt, 1'b1);
        check("t6_mem_addr", mem_addr, 32'h208);
        check("t6_mem_we", mem_we, 1'b0);
        ls_req = 1'b0;
        steps(3);
        check("t6_ls_rvalid", ls_rvalid, 1'b1);
        check("t6_ls_rdata", ls_rdata, 32'h0208FDF7);
        check("t6_if_rdata_hold", if_rdata, 32'h0104FEFB);

        if_req = 1'b1; if_addr = 32'h300;
        ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h200; ls_wdata = 32'h12345678; ls_be = 4'hF;
        steps(1);
        check("t2_ls_gnt", ls_gnt, 1'b1);
        check("t2_if_gnt", if_gnt, 1'b0);
        check("t2_mem_we", mem_we, 1'b1);
        check("t2_mem_addr", mem_addr, 32'h200);
        check("t2_mem_wdata", mem_wdata, 32'h12345678);
        check("t2_mem_be", mem_be, 4'hF);
        ls_req = 1'b0; ls_we = 1'b0;
        steps(3);
        check("t2_ls_rvalid", ls_rvalid, 1'b1);
        check("t2_ls_rdata_zero", ls_rdata, 32'h0);
        check("t2_if_gnt_wait", if_gnt, 1'b0);
        steps(1);
        check("t2_if_gnt", if_gnt, 1'b1);
        check("t2_if_mem_addr", mem_addr, 32'h300);
        check("t2_if_mem_we", mem_we, 1'b0);
        if_req = 1'b0;
        steps(3);
        check("t2_if_rvalid", if_rvalid, 1'b1);
        check("t2_if_rdata", if_rdata, 32'h0300FCFF);

        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h400; ls_be = 4'hF;
        if_req = 1'b1; if_addr = 32'h500;
        for (int k = 0; k < 6; k++) begin
            steps(1);
            check("t3_if_gnt", if_gnt, (k == 4));
            check("t3_ls_gnt", ls_gnt, (k != 4));
            if (k == 3) check("t3_starve_full", u_dut.starve_cnt_reg, 4'd4);
            if (k == 4) begin
                check("t3_if_addr", mem_addr, 32'h500);
                check("t3_starve_clr", u_dut.starve_cnt_reg, 4'd0);
            end
            if (k == 5) ls_req = 1'b0;
            steps(3);
        end
        steps(1);
        check("t3_if_final_gnt", if_gnt, 1'b1);
        if_req = 1'b0;
        steps(3);
        check("t3_if_rvalid", if_rvalid, 1'b1);
        check("t3_if_rdata", if_rdata, 32'h0500FAFF);

        ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h600;
        steps(1);
        check("t4_ls_gnt", ls_gnt, 1'b1);
        ls_req = 1'b0;
        steps(1);
        reset = 1'b0;
        steps(1);
        check("t4_mem_en", mem_en, 1'b0);
        check("t4_busy", busy, 1'b0);
        check("t4_ls_rvalid", ls_rvalid, 1'b0);
        check("t4_mem_addr", mem_addr, 32'h0);
        check("t4_if_rdata", if_rdata, 32'h0);
        reset = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            steps(1);
            if (ls_rvalid || mem_en) seen = 1'b1;
        end
        check("t4_no_stray_resp", seen, 1'b0);
        check("t4_busy_after", busy, 1'b0);

        lg1 = -1; le1 = -1; nr1 = 0; lg15 = -1; le15 = -1; nr15 = 0;
        if_req_sw = 1'b1;
        for (int k = 0; k < 90; k++) begin
            steps(1);
            if (l1_if_gnt) lg1 = cyc;
            if (l1_en) begin
                if (le1 >= 0) check("t5_l1_en_spacing", cyc - le1, 3);
                le1 = cyc;
            end
            if (l1_if_rvalid) begin
                check("t5_l1_gnt_to_rvalid", cyc - lg1, 2);
                check("t5_l1_rdata", l1_if_rdata, 32'h0040FFBF);
                nr1++;
            end
            if (l15_if_gnt) lg15 = cyc;
            if (l15_en) begin
                if (le15 >= 0) check("t5_l15_en_spacing", cyc - le15, 17);
                le15 = cyc;
            end
            if (l15_if_rvalid) begin
                check("t5_l15_gnt_to_rvalid", cyc - lg15, 16);
                check("t5_l15_rdata", l15_if_rdata, 32'h0040FFBF);
                nr15++;
            end
        end
        if_req_sw = 1'b0;
        check("t5_l1_count", (nr1 >= 20), 1'b1);
        check("t5_l15_count", (nr15 >= 4), 1'b1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
